// File: rtl/display_fb_arbiter.sv
// Frame-buffer RAM arbiter: scanout reads take priority over buffered camera writes.
// A starvation counter forces a write slot so that pixel writes always drain.
module display_fb_arbiter #(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned MEM_DEPTH   = 100048,
   parameter int unsigned WFIFO_DEPTH = 4,
   parameter int unsigned MAX_WAIT    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   // camera pixel writer
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic [DATA_W/8-1:0]            wr_be,
   // scanout reader
   input  logic                           rd_valid,
   output logic                           rd_ready,
   input  logic [ADDR_W-1:0]              rd_addr,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_data_valid,
   // RAM slave port
   output logic [ADDR_W-1:0]              mem_address,
   output logic [DATA_W/8-1:0]            mem_byteenable,
   output logic                           mem_chipselect,
   output logic                           mem_write,
   output logic [DATA_W-1:0]              mem_writedata,
   output logic                           mem_clken,
   input  logic [DATA_W-1:0]              mem_readdata,
   // status
   output logic [$clog2(WFIFO_DEPTH):0]   fifo_level,
   output logic                           oob_err,
   input  logic                           err_clear
);

   localparam int unsigned BeW  = DATA_W / 8;
   localparam int unsigned PtrW = $clog2(WFIFO_DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   localparam logic [LvlW-1:0]   FullLvl   = LvlW'(WFIFO_DEPTH);
   localparam logic [7:0]        MaxWait   = 8'(MAX_WAIT);
   localparam logic [ADDR_W:0]   MemDepthW = (ADDR_W + 1)'(MEM_DEPTH);

   typedef enum logic [1:0] {
      GntIdle,
      GntRead,
      GntWrite,
      GntForce
   } grant_e;

   // ------------------------------------------------------------------
   // Write FIFO
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] fifo_addr_mem [WFIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_mem [WFIFO_DEPTH];
   logic [BeW-1:0]    fifo_be_mem   [WFIFO_DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0] level_q, level_d;

   logic fifo_full;
   logic fifo_ne;
   logic push;
   logic pop;

   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [BeW-1:0]    head_be;

   assign fifo_full = (level_q == FullLvl);
   assign fifo_ne   = (level_q != '0);
   assign wr_ready  = !reset && !fifo_full;
   assign push      = wr_valid && wr_ready;

   assign head_addr = fifo_addr_mem[rd_ptr_q];
   assign head_data = fifo_data_mem[rd_ptr_q];
   assign head_be   = fifo_be_mem[rd_ptr_q];

   // Storage needs no reset; validity is tracked entirely by level_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_mem[wr_ptr_q] <= wr_addr;
         fifo_data_mem[wr_ptr_q] <= wr_data;
         fifo_be_mem[wr_ptr_q]   <= wr_be;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   assign fifo_level = level_q;

   // ------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------
   logic [7:0] starve_q, starve_d;
   grant_e     grant;
   logic       rd_gnt;
   logic       wr_gnt;
   logic       head_oob;
   logic       rd_oob;

   assign head_oob = ({1'b0, head_addr} >= MemDepthW);
   assign rd_oob   = ({1'b0, rd_addr} >= MemDepthW);

   always_comb begin
      grant = GntIdle;
      if (!reset) begin
         if (fifo_ne && (starve_q == MaxWait)) begin
            grant = GntForce;
         end else if (rd_valid) begin
            grant = GntRead;
         end else if (fifo_ne) begin
            grant = GntWrite;
         end
      end
   end

   assign rd_gnt   = (grant == GntRead);
   assign wr_gnt   = (grant == GntWrite) || (grant == GntForce);
   assign rd_ready = rd_gnt;
   // An out-of-range head is still consumed so the writer never stalls on it.
   assign pop      = wr_gnt;

   always_comb begin
      starve_d = starve_q;
      if (wr_gnt || !fifo_ne) begin
         starve_d = '0;
      end else if (rd_gnt) begin
         starve_d = starve_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // RAM drive: combinational, the RAM registers the address itself
   // ------------------------------------------------------------------
   always_comb begin
      mem_address    = rd_addr;
      mem_byteenable = '1;
      mem_writedata  = head_data;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      if (wr_gnt) begin
         mem_address    = head_addr;
         mem_byteenable = head_be;
         mem_chipselect = !head_oob;
         mem_write      = !head_oob;
      end else if (rd_gnt) begin
         mem_chipselect = !rd_oob;
      end
   end

   assign mem_clken = 1'b1;

   // ------------------------------------------------------------------
   // Read return and error flag
   // ------------------------------------------------------------------
   logic rd_valid_q, rd_valid_d;
   logic rd_zero_q, rd_zero_d;
   logic err_q, err_d;
   logic oob_hit;

   assign oob_hit = (wr_gnt && head_oob) || (rd_gnt && rd_oob);

   always_comb begin
      rd_valid_d = rd_gnt;
      rd_zero_d  = rd_gnt && rd_oob;
      err_d      = err_q;
      if (oob_hit) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end
   end

   assign rd_data_valid = rd_valid_q;
   assign rd_data       = rd_zero_q ? '0 : mem_readdata;
   assign oob_err       = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         starve_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_zero_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         starve_q   <= starve_d;
         rd_valid_q <= rd_valid_d;
         rd_zero_q  <= rd_zero_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_display_fb_arbiter.sv
// Bench for display_fb_arbiter: RAM model plus a queue-based transaction-level reference,
// directed scenarios followed by randomized traffic.
module tb_display_fb_arbiter;

   localparam int MEM_DEPTH = 100048;
   localparam int MAX_WAIT  = 8;
   localparam int WFD       = 4;

   logic        clk;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [16:0] wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_valid;
   logic        rd_ready;
   logic [16:0] rd_addr;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic [16:0] mem_address;
   logic [1:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [15:0] mem_writedata;
   logic        mem_clken;
   logic [15:0] mem_readdata;
   logic [2:0]  fifo_level;
   logic        oob_err;
   logic        err_clear;

   display_fb_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_be          (wr_be),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_data_valid  (rd_data_valid),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .fifo_level     (fifo_level),
      .oob_err        (oob_err),
      .err_clear      (err_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with registered read and byte-enabled write
   logic [15:0] ram [0:131071];
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   // Reference model: pending-write queue, consecutive-read count, shadow frame buffer
   typedef struct packed {
      logic [16:0] a;
      logic [15:0] d;
      logic [1:0]  be;
   } wr_t;

   wr_t         wq [$];
   int          starve;
   bit          exp_rdv;
   logic [15:0] exp_rdata;
   bit          exp_err;
   logic [15:0] ref_mem [0:131071];

   int n_checks;
   int n_errors;

   logic        obs_wr_ready, obs_rd_ready, obs_cs, obs_write, obs_rdv, obs_err;
   logic [15:0] obs_rdata;
   logic [2:0]  obs_level;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs (called at posedge+1), checks at negedge, advances the model.
   task automatic cycle(input bit rst, input bit wv, input logic [16:0] wa, input logic [15:0] wd,
                        input logic [1:0] wbe, input bit rv, input logic [16:0] ra, input bit ec);
      int  g;
      bit  ne, wrdy, oob;
      wr_t h;
      reset     = rst;
      wr_valid  = wv;
      wr_addr   = wa;
      wr_data   = wd;
      wr_be     = wbe;
      rd_valid  = rv;
      rd_addr   = ra;
      err_clear = ec;
      @(negedge clk);
      if (rst) begin
         wq.delete();
         starve  = 0;
         exp_rdv = 0;
         exp_err = 0;
      end
      ne   = (wq.size() != 0);
      wrdy = !rst && (wq.size() < WFD);
      g    = 0;  // 0 idle, 1 read, 2 write
      if (!rst) begin
         if (ne && starve == MAX_WAIT) g = 2;
         else if (rv)                  g = 1;
         else if (ne)                  g = 2;
      end
      h   = '0;
      oob = 0;
      if (g == 2) begin
         h   = wq[0];
         oob = (int'(h.a) >= MEM_DEPTH);
      end
      if (g == 1) oob = (int'(ra) >= MEM_DEPTH);

      obs_wr_ready = wr_ready;
      obs_rd_ready = rd_ready;
      obs_cs       = mem_chipselect;
      obs_write    = mem_write;
      obs_rdv      = rd_data_valid;
      obs_rdata    = rd_data;
      obs_err      = oob_err;
      obs_level    = fifo_level;

      check_eq("wr_ready", 32'(wr_ready), 32'(wrdy));
      check_eq("rd_ready", 32'(rd_ready), 32'(g == 1));
      check_eq("fifo_level", 32'(fifo_level), 32'(wq.size()));
      check_eq("rd_data_valid", 32'(rd_data_valid), 32'(exp_rdv));
      if (exp_rdv) check_eq("rd_data", 32'(rd_data), 32'(exp_rdata));
      check_eq("oob_err", 32'(oob_err), 32'(exp_err));
      check_eq("mem_chipselect", 32'(mem_chipselect), 32'(g != 0 && !oob));
      check_eq("mem_write", 32'(mem_write), 32'(g == 2 && !oob));
      check_eq("mem_clken", 32'(mem_clken), 32'd1);
      if (g == 2 && !oob) begin
         check_eq("wr_address", 32'(mem_address), 32'(h.a));
         check_eq("wr_writedata", 32'(mem_writedata), 32'(h.d));
         check_eq("wr_byteenable", 32'(mem_byteenable), 32'(h.be));
      end
      if (g == 1 && !oob) begin
         check_eq("rd_address", 32'(mem_address), 32'(ra));
         check_eq("rd_byteenable", 32'(mem_byteenable), 32'd3);
      end

      exp_rdv = (g == 1);
      if (g == 1) exp_rdata = oob ? 16'h0 : ref_mem[ra];
      if (g != 0 && oob) exp_err = 1;
      else if (ec && !rst) exp_err = 0;
      if (g == 2 || !ne) starve = 0;
      else if (g == 1)   starve++;
      if (g == 2) begin
         void'(wq.pop_front());
         if (!oob) begin
            if (h.be[0]) ref_mem[h.a][7:0]  = h.d[7:0];
            if (h.be[1]) ref_mem[h.a][15:8] = h.d[15:8];
         end
      end
      if (wv && wrdy) wq.push_back('{a: wa, d: wd, be: wbe});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 17'h0, 16'h0, 2'b00, 0, 17'h0, 0);
   endtask

   function automatic logic [16:0] rand_addr();
      case ($urandom_range(0, 9))
         7:       return 17'(MEM_DEPTH - 1);
         8:       return 17'($urandom_range(MEM_DEPTH, 131071));
         9:       return 17'($urandom_range(0, MEM_DEPTH - 1));
         default: return 17'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int n;
      int rv_pct;
      int wv_pct;
      n_checks = 0;
      n_errors = 0;
      starve   = 0;
      exp_rdv  = 0;
      exp_err  = 0;
      exp_rdata = '0;
      for (int i = 0; i < 131072; i++) begin
         ram[i]     = 16'h0;
         ref_mem[i] = 16'h0;
      end
      mem_readdata = 16'h0;
      reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_valid = 1'b0; rd_addr = '0; err_clear = 1'b0;
      @(posedge clk);
      #1;

      // Reset values, with requests present
      cycle(1, 1, 17'h1, 16'h1, 2'b11, 1, 17'h1, 0);
      check_eq("rst_level", 32'(obs_level), 32'd0);
      check_eq("rst_wr_ready", 32'(obs_wr_ready), 32'd0);
      check_eq("rst_rd_ready", 32'(obs_rd_ready), 32'd0);
      idle(2);

      // Single write then read
      cycle(0, 1, 17'h00010, 16'hBEEF, 2'b11, 0, 17'h0, 0);
      check_eq("no_bypass", 32'(obs_write), 32'd0);
      idle(1);
      check_eq("wr_latency", 32'(obs_write), 32'd1);
      cycle(0, 0, 17'h0, 16'h0, 2'b00, 1, 17'h00010, 0);
      check_eq("rd_grant", 32'(obs_rd_ready), 32'd1);
      idle(1);
      check_eq("rd_valid_lat", 32'(obs_rdv), 32'd1);
      check_eq("rd_beef", 32'(obs_rdata), 32'h0000BEEF);

      // Byte-enable merge
      cycle(0, 1, 17'd5, 16'h1234, 2'b11, 0, 17'h0, 0);
      cycle(0, 1, 17'd5, 16'hAB00, 2'b10, 0, 17'h0, 0);
      idle(2);
      cycle(0, 0, 17'h0, 16'h0, 2'b00, 1, 17'd5, 0);
      idle(1);
      check_eq("be_merge", 32'(obs_rdata), 32'h0000AB34);

      // Starvation: one pending write under continuous reads
      idle(4);
      cycle(0, 1, 17'h20, 16'h5A5A, 2'b11, 1, 17'h3, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 17'h0, 16'h0, 2'b00, 1, 17'(i), 0);
         if (obs_rd_ready) n++;
         else break;
      end
      check_eq("starve_grants", 32'(n), 32'(MAX_WAIT));
      check_eq("starve_write", 32'(obs_write), 32'd1);
      cycle(0, 0, 17'h0, 16'h0, 2'b00, 1, 17'h4, 0);
      check_eq("starve_resume", 32'(obs_rd_ready), 32'd1);

      // FIFO full under continuous reads
      idle(4);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 17'(16'h40 + i), 16'(16'hC000 + i), 2'b11, 1, 17'(i), 0);
      end
      cycle(0, 1, 17'h50, 16'hDEAD, 2'b11, 1, 17'h7, 0);
      check_eq("full_ready", 32'(obs_wr_ready), 32'd0);
      check_eq("full_level", 32'(obs_level), 32'd4);
      for (int i = 0; i < 40; i++) begin
         cycle(0, 1, 17'(16'h60 + i), 16'($urandom), 2'($urandom), 1, 17'(16'h40 + i % 8), 0);
      end
      idle(8);

      // Out-of-range write and read, then clear
      cycle(0, 1, 17'(MEM_DEPTH), 16'hFFFF, 2'b11, 0, 17'h0, 0);
      idle(1);
      check_eq("oob_wr_cs", 32'(obs_cs), 32'd0);
      check_eq("oob_wr_level", 32'(obs_level), 32'd1);
      cycle(0, 0, 17'h0, 16'h0, 2'b00, 1, 17'(MEM_DEPTH), 0);
      check_eq("oob_rd_grant", 32'(obs_rd_ready), 32'd1);
      check_eq("oob_rd_cs", 32'(obs_cs), 32'd0);
      idle(1);
      check_eq("oob_rd_valid", 32'(obs_rdv), 32'd1);
      check_eq("oob_rd_zero", 32'(obs_rdata), 32'd0);
      check_eq("oob_flag", 32'(obs_err), 32'd1);
      cycle(0, 0, 17'h0, 16'h0, 2'b00, 0, 17'h0, 1);
      idle(1);
      check_eq("oob_cleared", 32'(obs_err), 32'd0);

      // Reset mid-stream: three writes pending and a read in flight
      idle(4);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 17'(16'h70 + i), 16'h7777, 2'b11, 1, 17'h70, 0);
      end
      cycle(1, 1, 17'h80, 16'h8888, 2'b11, 1, 17'h70, 0);
      check_eq("mid_rst_level", 32'(obs_level), 32'd0);
      check_eq("mid_rst_rdv", 32'(obs_rdv), 32'd0);
      check_eq("mid_rst_write", 32'(obs_write), 32'd0);
      idle(1);
      check_eq("post_rst_ready", 32'(obs_wr_ready), 32'd1);
      check_eq("post_rst_rdv", 32'(obs_rdv), 32'd0);

      // Randomized traffic in phases of varying read/write pressure
      for (int p = 0; p < 12; p++) begin
         rv_pct = $urandom_range(0, 100);
         wv_pct = $urandom_range(10, 100);
         for (int i = 0; i < 250; i++) begin
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 99) < wv_pct), rand_addr(), 16'($urandom), 2'($urandom),
                  ($urandom_range(0, 99) < rv_pct), rand_addr(),
                  ($urandom_range(0, 29) == 0));
         end
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/display_fb_arbiter.md
Name: display_fb_arbiter

Overview:
- Shares the single-port 16-bit display frame-buffer RAM (17-bit word address, 2-byte byteenable, 1-cycle read latency) between two requesters.
  - The camera pixel writer, buffered through a small write FIFO.
  - The display scanout reader, which has priority.
- A starvation counter forces a write slot periodically, so the writer always makes progress.
- Sits between the pixel pipeline / scanout engine and the on-chip RAM's Avalon-style slave port.

Parameters:
- ADDR_W, 17, word address width.
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- MEM_DEPTH, 100048, valid word count; addresses >= MEM_DEPTH are out of range.
- WFIFO_DEPTH, 4, write FIFO entries (power of two, >= 2).
- MAX_WAIT, 8, maximum consecutive read grants while the write FIFO is non-empty (1..255).

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer accept; transfer occurs when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  write byte enables.
- rd_valid  in  1  reader request.
- rd_ready  out  1  read accepted this cycle (grant).
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read data.
- rd_data_valid  out  1  rd_data valid; one cycle after grant.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM; constant 1.
- mem_readdata  in  DATA_W  from RAM (valid the cycle after the address is presented).
- fifo_level  out  clog2(WFIFO_DEPTH)+1  current write FIFO occupancy.
- oob_err  out  1  sticky out-of-range access flag.
- err_clear  in  1  synchronous clear of oob_err.

Behaviour:
- Reset values:
  - FIFO empty, fifo_level=0.
  - starve counter=0, rd_data_valid=0, oob_err=0.
  - wr_ready=0 and rd_ready=0 while reset is asserted.
  - mem_chipselect=0, mem_write=0.
- Reset mid-operation discards FIFO contents and any in-flight read; no rd_data_valid follows.
- Write FIFO:
  - wr_ready = !full.
  - Push on wr_valid & wr_ready.
  - No bypass: an entry is issued to the RAM no earlier than the cycle after it is pushed, so minimum accept-to-RAM-write latency is 1 cycle.
  - Simultaneous push and pop is allowed (level unchanged); when full, wr_ready=0 and no push occurs.
- Grant decision, combinational, once per cycle, in priority order:
  - FORCE_WR: FIFO non-empty and starve == MAX_WAIT -> write grant, rd_ready=0.
  - READ: rd_valid -> read grant, rd_ready=1.
  - WRITE: FIFO non-empty -> write grant.
  - IDLE: mem_chipselect=0.
- Starve counter (8-bit):
  - +1 on each read grant while the FIFO is non-empty.
  - Cleared to 0 on a write grant or when the FIFO is empty.
  - Never exceeds MAX_WAIT.
- Memory drive:
  - Read grant: mem_address=rd_addr, mem_chipselect=1, mem_write=0, mem_byteenable=all ones.
  - Write grant: mem_address/mem_writedata/mem_byteenable from the FIFO head, mem_chipselect=1, mem_write=1; the FIFO pops the same cycle.
  - Outputs are combinational from the grant, because the RAM registers its address.
- Read return:
  - rd_data_valid is registered: 1 in the cycle after each read grant.
  - rd_data = mem_readdata in that cycle; forced to 0 when the granted address was out of range.
  - Back-to-back reads sustain one word per cycle.
- Out of range (addr >= MEM_DEPTH):
  - Write: dropped; FIFO still pops, mem_chipselect=0 that cycle, oob_err set.
  - Read: granted normally but mem_chipselect=0; rd_data_valid still pulses with rd_data=0, oob_err set.
  - Check on the FIFO head / rd_addr at grant time.
- err_clear: clears oob_err next cycle; a simultaneous new error wins (flag stays 1).
- Arithmetic: FIFO pointers are ADDR-free, log2(WFIFO_DEPTH) bits, and wrap modulo depth; full/empty is resolved by the extra level bit.

Test Plan:
- Reset mid-stream: assert reset with 3 FIFO entries pending and a read in flight -> fifo_level=0, rd_data_valid=0 next cycle, no mem_write; after release wr_ready=1.
- Single write then read: write 0xBEEF to addr 0x00010 with be=2'b11, then read 0x00010 -> mem_write pulse 1 cycle after accept; rd_data=0xBEEF with rd_data_valid exactly 1 cycle after rd_ready.
- Byte-enable merge: write 0x1234 be=11, then 0xAB00 be=10 to addr 5; read addr 5 -> 0xAB34.
- Starvation: rd_valid held high continuously, push 1 write -> rd_ready drops for exactly one cycle after 8 read grants (MAX_WAIT=8) and the write lands in that cycle.
- FIFO full: rd_valid high, push 4 writes with MAX_WAIT=8 -> wr_ready=0 after the 4th push, fifo_level=4; each forced write slot frees one entry.
- Out-of-range: write to 100048, then read 100048 -> no mem_chipselect either cycle, oob_err=1, rd_data=0 with valid; err_clear -> oob_err=0.
